// File: rtl/sfifo.sv
// Single-clock first-word-fall-through FIFO between two valid/ready streams.
// Define SFIFO_ASSERT_EN to compile in simulation-only protocol assertions.
module sfifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 256
) (
  input  logic clock,
  input  logic reset,
  input  T     receiver_data_i,
  input  logic receiver_valid_i,
  output logic receiver_ready_o,
  output T     sender_data_o,
  output logic sender_valid_o,
  input  logic sender_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          valid_q, valid_d;
  T              data_q, data_d;
  logic          push, pop;

  assign receiver_ready_o = reset & ~full_q;
  assign sender_valid_o   = valid_q;
  assign sender_data_o    = data_q;
  assign push             = receiver_valid_i & receiver_ready_o;
  assign pop              = valid_q & sender_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL);
    valid_d = (count_d != '0);
    // The next head may be the word being written this very edge.
    if (valid_d) begin
      if (push && (wr_ptr_q == rd_ptr_d)) data_d = receiver_data_i;
      else                                data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

  // Output data register and storage keep their contents through reset.
  always_ff @(posedge clock) begin
    data_q <= data_d;
    if (push) mem_q[wr_ptr_q] <= receiver_data_i;
  end

`ifdef SFIFO_ASSERT_EN
  if (DEPTH < 2) begin : g_depth_chk
    $error("sfifo: DEPTH must be >= 2");
  end

  a_count_range: assert property (@(posedge clock) disable iff (!reset)
    count_q <= FULL)
    else $error("sfifo: count exceeds DEPTH or underflowed");

  a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
    !(push && (count_q == FULL)))
    else $error("sfifo: push while full");

  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset)
    !(pop && (count_q == '0)))
    else $error("sfifo: pop while empty");

  a_stable_out: assert property (@(posedge clock) disable iff (!reset)
    (valid_q && !sender_ready_i) |=> (valid_q && $stable(data_q)))
    else $error("sfifo: sender output changed while stalled");
`else
  // Assertion checks compiled out; functional logic above is unaffected.
`endif

endmodule

// File: tb/tb_sfifo.sv
// Self-checking bench for sfifo: DEPTH=256 directed tests plus a DEPTH=5 random-stall run.
module tb_sfifo;
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [31:0] a_rx_data, a_tx_data, b_rx_data, b_tx_data;
  logic        a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready;
  logic        b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready;

  sfifo #(.DEPTH(256)) u_a (
    .clock(clk), .reset(rst_n),
    .receiver_data_i(a_rx_data), .receiver_valid_i(a_rx_valid), .receiver_ready_o(a_rx_ready),
    .sender_data_o(a_tx_data), .sender_valid_o(a_tx_valid), .sender_ready_i(a_tx_ready));

  sfifo #(.DEPTH(5)) u_b (
    .clock(clk), .reset(rst_n),
    .receiver_data_i(b_rx_data), .receiver_valid_i(b_rx_valid), .receiver_ready_o(b_rx_ready),
    .sender_data_o(b_tx_data), .sender_valid_o(b_tx_valid), .sender_ready_i(b_tx_ready));

  int tests = 0;
  int fails = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int b_pushed = 0;
  int b_popped = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check A against the model, account for the handshakes, then advance one clock.
  task automatic cyc_a();
    logic [31:0] exp;
    chk("a_ready", {31'd0, a_rx_ready}, {31'd0, rst_n && (qa.size() < 256)});
    chk("a_valid", {31'd0, a_tx_valid}, {31'd0, qa.size() != 0});
    if (a_tx_valid && a_tx_ready && qa.size() != 0) begin
      exp = qa.pop_front();
      chk("a_data", a_tx_data, exp);
    end
    if (a_rx_valid && a_rx_ready) qa.push_back(a_rx_data);
    @(posedge clk); #1;
  endtask

  task automatic cyc_b();
    logic [31:0] exp;
    chk("b_ready", {31'd0, b_rx_ready}, {31'd0, rst_n && (qb.size() < 5)});
    chk("b_valid", {31'd0, b_tx_valid}, {31'd0, qb.size() != 0});
    if (b_tx_valid && b_tx_ready && qb.size() != 0) begin
      exp = qb.pop_front();
      chk("b_data", b_tx_data, exp);
      b_popped++;
    end
    if (b_rx_valid && b_rx_ready) begin
      qb.push_back(b_rx_data);
      b_pushed++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_rx_data = 32'h1111_2222; a_rx_valid = 1'b1; a_tx_ready = 1'b0;
    b_rx_data = '0;            b_rx_valid = 1'b0; b_tx_ready = 1'b0;
    #1;

    // Reset held with valid asserted: nothing accepted, nothing offered.
    for (int i = 0; i < 3; i++) cyc_a();
    rst_n = 1'b1;
    a_rx_valid = 1'b0;
    #1;
    chk("rel_ready", {31'd0, a_rx_ready}, 32'd1);
    chk("rel_valid", {31'd0, a_tx_valid}, 32'd0);
    @(posedge clk); #1;

    // Single word, minimum latency.
    a_rx_data = 32'hDEAD_BEEF; a_rx_valid = 1'b1; a_tx_ready = 1'b1;
    cyc_a();
    a_rx_valid = 1'b0;
    chk("single_valid", {31'd0, a_tx_valid}, 32'd1);
    chk("single_data", a_tx_data, 32'hDEAD_BEEF);
    cyc_a();
    cyc_a();

    // Fill to DEPTH, attempt one extra, then drain in order.
    a_tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a_rx_valid = 1'b1; a_rx_data = i;
      cyc_a();
    end
    chk("full_ready", {31'd0, a_rx_ready}, 32'd0);
    a_rx_data = 32'h1234_5678;
    cyc_a();
    cyc_a();
    a_rx_valid = 1'b0; a_tx_ready = 1'b1;
    chk("drain_head", a_tx_data, 32'd0);
    for (int i = 0; i < 256; i++) cyc_a();
    cyc_a();
    chk("drained_valid", {31'd0, a_tx_valid}, 32'd0);

    // Simultaneous push/pop with 10 words resident.
    a_tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_rx_valid = 1'b1; a_rx_data = 32'h100 + i;
      cyc_a();
    end
    a_tx_ready = 1'b1;
    for (int i = 10; i < 30; i++) begin
      a_rx_data = 32'h100 + i;
      cyc_a();
    end
    a_rx_valid = 1'b0;
    for (int i = 0; i < 11; i++) cyc_a();

    // DEPTH=5 wrap with random stalls on both sides.
    for (int c = 0; c < 20000 && (b_pushed < 1000 || qb.size() != 0); c++) begin
      b_rx_valid = (b_pushed < 1000) && ($urandom_range(0, 3) != 0);
      b_rx_data  = 32'hB000_0000 + b_pushed;
      b_tx_ready = ($urandom_range(0, 2) != 0);
      cyc_b();
    end
    chk("b_popped", b_popped, 32'd1000);
    b_rx_valid = 1'b0; b_tx_ready = 1'b0;

    // Reset mid-stream with 7 words held.
    a_tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_rx_valid = 1'b1; a_rx_data = 32'h700 + i;
      cyc_a();
    end
    a_rx_valid = 1'b0;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("mid_rst_valid", {31'd0, a_tx_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, a_rx_ready}, 32'd0);
    cyc_a();
    rst_n = 1'b1;
    #1;
    a_rx_valid = 1'b1; a_rx_data = 32'hCAFE_0001; a_tx_ready = 1'b1;
    cyc_a();
    a_rx_valid = 1'b0;
    chk("post_rst_data", a_tx_data, 32'hCAFE_0001);
    cyc_a();
    cyc_a();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
